// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state, select encodings and instruction-class indices
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] IMM_R = 3'b000, IMM_I = 3'b001, IMM_B = 3'b010;
    localparam logic [2:0] IMM_S = 3'b011, IMM_U = 3'b100, IMM_J = 3'b101;
    localparam logic [1:0] RD_ALU = 2'b00, RD_PC4 = 2'b01, RD_IMM = 2'b10;
    localparam logic [1:0] A_RS1 = 2'b00, A_PC = 2'b01, A_PCJ = 2'b10;
    localparam logic [1:0] PC_PLUS4 = 2'b00, PC_IMM = 2'b01, PC_RS1 = 2'b10;

    // Flag vector bit k maps to class k+1; class 0 means "nothing latched"
    localparam int NCLS = 9;
    typedef logic [3:0] cls_t;
    localparam cls_t CLS_NONE = 4'd0, CLS_R = 4'd1, CLS_I = 4'd2, CLS_S = 4'd3;
    localparam cls_t CLS_B = 4'd4, CLS_L = 4'd5, CLS_JAL = 4'd6, CLS_JALR = 4'd7;
    localparam cls_t CLS_AUIPC = 4'd8, CLS_LUI = 4'd9;

    // {imme_sel, rd_sel, rs1_sel} for a latched class
    function automatic logic [6:0] sel_decode(cls_t c);
        case (c)
            CLS_I, CLS_L: sel_decode = {IMM_I, RD_ALU, A_RS1};
            CLS_S:        sel_decode = {IMM_S, RD_ALU, A_RS1};
            CLS_B:        sel_decode = {IMM_B, RD_ALU, A_PC};
            CLS_JAL:      sel_decode = {IMM_J, RD_PC4, A_PCJ};
            CLS_JALR:     sel_decode = {IMM_I, RD_PC4, A_RS1};
            CLS_AUIPC:    sel_decode = {IMM_U, RD_ALU, A_PC};
            CLS_LUI:      sel_decode = {IMM_U, RD_IMM, A_PC};
            default:      sel_decode = {IMM_R, RD_ALU, A_RS1};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: decoder flags, memory handshakes and datapath controls
interface multicycle_controller_if;
    import riscv_ctrl_pkg::*;

    logic r_type, i_type, store, branch, load, jal, jalr, auipc, lui;
    logic branch_taken, imem_ready, dmem_ready;
    logic imem_req, dmem_req, ir_en, pc_en, reg_write, mem_write, we_re, illegal;
    logic [2:0] imme_sel, state;
    logic [1:0] rd_sel, rs1_sel, pc_sel;
    logic [31:0] instret;

    modport master (
        output r_type, i_type, store, branch, load, jal, jalr, auipc, lui,
        output branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ir_en, pc_en, reg_write, mem_write, we_re, illegal,
        input  imme_sel, state, rd_sel, rs1_sel, pc_sel, instret
    );

    modport slave (
        input  r_type, i_type, store, branch, load, jal, jalr, auipc, lui,
        input  branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, ir_en, pc_en, reg_write, mem_write, we_re, illegal,
        output imme_sel, state, rd_sel, rs1_sel, pc_sel, instret
    );

endinterface

// File: rtl/instr_class_encoder.sv
// instr_class_encoder: one-hot check of decoder flags and class index encoding
module instr_class_encoder
    import riscv_ctrl_pkg::*;
(
    input  logic [NCLS-1:0] i_flags,
    output cls_t            o_class,
    output logic            o_illegal
);

    // Zero or several flags is undecodable and yields no class
    always_comb begin
        o_class   = CLS_NONE;
        o_illegal = !$onehot(i_flags);
        for (int k = 0; k < NCLS; k++)
            if (i_flags[k]) o_class = cls_t'(k + 1);
        if (o_illegal) o_class = CLS_NONE;
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RISC-V core
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    multicycle_controller_if.slave bus
);

    state_t      r_state, w_next;
    cls_t        r_class, w_class;
    logic        w_bad, w_ir_en, w_illegal, w_pc_en;
    logic        r_imem_req, r_dmem_req, r_mem_write, r_we_re, r_reg_write;
    logic [1:0]  w_pc_sel;
    logic [31:0] r_instret;

    instr_class_encoder u_enc (
        .i_flags   ({bus.lui, bus.auipc, bus.jalr, bus.jal, bus.load,
                     bus.branch, bus.store, bus.i_type, bus.r_type}),
        .o_class   (w_class),
        .o_illegal (w_bad)
    );

    // Next state; ready strobes only matter in the state that owns them
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = bus.imem_ready ? DECODE : FETCH;
            DECODE:  w_next = w_bad ? FETCH : EXEC;
            EXEC:    w_next = (r_class == CLS_B) ? FETCH :
                              (r_class == CLS_L || r_class == CLS_S) ? MEM : WB;
            MEM:     w_next = !bus.dmem_ready ? MEM : (r_class == CLS_S) ? FETCH : WB;
            default: w_next = FETCH;
        endcase
    end

    // Strobes that depend on same-cycle inputs; forced low while in reset
    always_comb begin
        w_ir_en   = rst_n && r_state == FETCH && bus.imem_ready;
        w_illegal = rst_n && r_state == DECODE && w_bad;
        w_pc_en   = rst_n && (w_illegal || r_state == WB ||
                              (r_state == EXEC && r_class == CLS_B) ||
                              (r_state == MEM && r_class == CLS_S && bus.dmem_ready));
        w_pc_sel  = (r_state == EXEC && r_class == CLS_B && bus.branch_taken) ? PC_IMM :
                    (r_state == WB && r_class == CLS_JAL) ? PC_IMM :
                    (r_state == WB && r_class == CLS_JALR) ? PC_RS1 : PC_PLUS4;
    end

    // State, class register and state-entry outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_class     <= CLS_NONE;
            r_imem_req  <= 1'b1;
            r_dmem_req  <= 1'b0;
            r_mem_write <= 1'b0;
            r_we_re     <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            r_state     <= w_next;
            if (r_state == DECODE) r_class <= w_class;
            r_imem_req  <= w_next == FETCH;
            r_dmem_req  <= w_next == MEM;
            r_mem_write <= w_next == MEM && r_class == CLS_S;
            r_we_re     <= w_next == MEM && r_class == CLS_L;
            r_reg_write <= w_next == WB;
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_instret <= '0;
        else if (w_pc_en && !w_illegal) r_instret <= r_instret + 32'd1;
    end

    assign bus.state     = r_state;
    assign bus.imem_req  = r_imem_req;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.mem_write = r_mem_write;
    assign bus.we_re     = r_we_re;
    assign bus.reg_write = r_reg_write;
    assign bus.ir_en     = w_ir_en;
    assign bus.illegal   = w_illegal;
    assign bus.pc_en     = w_pc_en;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.instret   = r_instret;
    assign {bus.imme_sel, bus.rd_sel, bus.rs1_sel} = sel_decode(r_class);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked cycle by cycle against a behavioural model
module tb_multicycle_controller;

    typedef struct packed {
        logic        rst;
        logic [8:0]  fl;
        logic        tk, ir, dr;
    } in_t;

    typedef struct packed {
        logic        chk;
        logic [2:0]  st;
        logic        imem_req, dmem_req, ir_en, pc_en, reg_write, mem_write, we_re, illegal;
        logic [2:0]  imme;
        logic [1:0]  rd, rs1, pc_sel;
        logic [31:0] instret;
    } exp_t;

    localparam logic [8:0] F_R = 9'h001, F_I = 9'h002, F_S = 9'h004, F_B = 9'h008, F_L = 9'h010;
    localparam logic [8:0] F_JAL = 9'h020, F_JALR = 9'h040, F_AUIPC = 9'h080, F_LUI = 9'h100;

    logic clk = 1'b0;
    logic rst_n;
    int checks = 0, errors = 0, lat;
    logic [31:0] m_instret = '0;
    logic [6:0] cur_sel = '0;
    exp_t q[$];

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected {imme_sel, rd_sel, rs1_sel} per flag position
    function automatic logic [6:0] sel_of(int idx);
        case (idx)
            1, 4:    sel_of = 7'b001_00_00;
            2:       sel_of = 7'b011_00_00;
            3:       sel_of = 7'b010_00_01;
            5:       sel_of = 7'b101_01_10;
            6:       sel_of = 7'b001_01_00;
            7:       sel_of = 7'b100_00_01;
            8:       sel_of = 7'b100_10_01;
            default: sel_of = 7'b000_00_00;
        endcase
    endfunction

    function automatic exp_t base(logic [2:0] st, logic chk);
        exp_t e = '0;
        e.st = st;
        e.chk = chk;
        e.instret = m_instret;
        if (chk) {e.imme, e.rd, e.rs1} = cur_sel;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic step(input in_t d, input exp_t e);
        @(posedge clk);
        #1;
        rst_n = !d.rst;
        {bus.lui, bus.auipc, bus.jalr, bus.jal, bus.load, bus.branch, bus.store, bus.i_type, bus.r_type} = d.fl;
        bus.branch_taken = d.tk;
        bus.imem_ready = d.ir;
        bus.dmem_ready = d.dr;
        q.push_back(e);
    endtask

    // One instruction: iw imem wait cycles, dw dmem wait cycles; ab stops after the first MEM cycle
    task automatic run_instr(input logic [8:0] fl, input logic tk, input int iw, input int dw,
                             input bit ab, output int lat_o);
        int n = 0, idx = 0;
        in_t d;
        exp_t e;
        lat_o = 0;
        for (int k = 0; k < 9; k++) if (fl[k]) begin n++; idx = k; end
        repeat (iw) begin
            d = '0; d.dr = 1'b1;
            e = base(3'd0, 1'b0); e.imem_req = 1'b1;
            step(d, e); lat_o++;
        end
        d = '0; d.ir = 1'b1;
        e = base(3'd0, 1'b0); e.imem_req = 1'b1; e.ir_en = 1'b1;
        step(d, e); lat_o++;
        d = '0; d.fl = fl; d.ir = 1'b1; d.dr = 1'b1;
        e = base(3'd1, 1'b0);
        if (n != 1) begin
            e.illegal = 1'b1; e.pc_en = 1'b1;
            step(d, e); lat_o++;
            return;
        end
        step(d, e); lat_o++;
        cur_sel = sel_of(idx);
        d = '0; d.tk = tk; d.ir = 1'b1; d.dr = 1'b1;
        e = base(3'd2, 1'b1);
        if (idx == 3) begin
            e.pc_en = 1'b1; e.pc_sel = tk ? 2'b01 : 2'b00;
            step(d, e); lat_o++; m_instret++;
            return;
        end
        step(d, e); lat_o++;
        if (idx == 2 || idx == 4) begin
            for (int w = 0; w <= dw; w++) begin
                d = '0; d.ir = 1'b1; d.dr = (w == dw);
                e = base(3'd3, 1'b1); e.dmem_req = 1'b1;
                e.mem_write = (idx == 2); e.we_re = (idx == 4);
                if (w == dw && idx == 2) e.pc_en = 1'b1;
                step(d, e); lat_o++;
                if (ab) return;
            end
            if (idx == 2) begin m_instret++; return; end
        end
        d = '0; d.ir = 1'b1; d.dr = 1'b1;
        e = base(3'd4, 1'b1); e.reg_write = 1'b1; e.pc_en = 1'b1;
        e.pc_sel = (idx == 5) ? 2'b01 : (idx == 6) ? 2'b10 : 2'b00;
        step(d, e); lat_o++; m_instret++;
    endtask

    // A FETCH wait cycle, then pin the retired count to a hand-computed value
    task automatic idle_check(input logic [31:0] want);
        exp_t e = base(3'd0, 1'b0);
        e.imem_req = 1'b1;
        step('0, e);
        chk("instret", bus.instret, want);
    endtask

    // Per-cycle comparison of every DUT output against the model's expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '0;
            a.chk = e.chk;
            a.st = bus.state;
            {a.imem_req, a.dmem_req, a.ir_en, a.pc_en} = {bus.imem_req, bus.dmem_req, bus.ir_en, bus.pc_en};
            {a.reg_write, a.mem_write, a.we_re, a.illegal} = {bus.reg_write, bus.mem_write, bus.we_re, bus.illegal};
            if (e.chk) {a.imme, a.rd, a.rs1} = {bus.imme_sel, bus.rd_sel, bus.rs1_sel};
            a.pc_sel = bus.pc_sel;
            a.instret = bus.instret;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle @%0t: got %h want %h", $time, a, e);
            end
        end
    end

    initial begin
        in_t d;
        exp_t e;
        rst_n = 1'b0;
        {bus.lui, bus.auipc, bus.jalr, bus.jal, bus.load, bus.branch, bus.store, bus.i_type, bus.r_type} = '0;
        {bus.branch_taken, bus.imem_ready, bus.dmem_ready} = '0;
        repeat (2) begin
            d = '0; d.rst = 1'b1; d.fl = '1; d.tk = 1'b1; d.ir = 1'b1; d.dr = 1'b1;
            e = base(3'd0, 1'b0); e.imem_req = 1'b1;
            step(d, e);
        end
        chk("rst_state", {29'd0, bus.state}, 32'd0);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rst_ir_en", {31'd0, bus.ir_en}, 32'd0);

        run_instr(F_R, 1'b0, 0, 0, 1'b0, lat);       chk("lat_r", lat, 4);      idle_check(1);
        run_instr(F_L, 1'b0, 0, 3, 1'b0, lat);       chk("lat_load3", lat, 8);  idle_check(2);
        run_instr(F_B, 1'b1, 0, 0, 1'b0, lat);       chk("lat_btaken", lat, 3); idle_check(3);
        run_instr(F_JALR, 1'b0, 0, 0, 1'b0, lat);    chk("lat_jalr", lat, 4);   idle_check(4);
        run_instr(F_L | F_S, 1'b0, 0, 0, 1'b0, lat); chk("lat_illegal", lat, 2); idle_check(4);
        run_instr(F_S, 1'b0, 2, 1, 1'b0, lat);       chk("lat_store", lat, 7);  idle_check(5);
        run_instr(F_JAL, 1'b0, 0, 0, 1'b0, lat);     chk("lat_jal", lat, 4);
        run_instr(F_AUIPC, 1'b0, 0, 0, 1'b0, lat);   chk("lat_auipc", lat, 4);
        run_instr(F_LUI, 1'b0, 0, 0, 1'b0, lat);     chk("lat_lui", lat, 4);
        run_instr(F_I, 1'b0, 1, 0, 1'b0, lat);       chk("lat_itype", lat, 5);
        run_instr(F_B, 1'b0, 0, 0, 1'b0, lat);       chk("lat_bnt", lat, 3);
        run_instr(F_S, 1'b0, 0, 0, 1'b0, lat);       chk("lat_store0", lat, 4);
        run_instr(9'h000, 1'b0, 0, 0, 1'b0, lat);    chk("lat_noflag", lat, 2); idle_check(11);

        run_instr(F_S, 1'b0, 0, 5, 1'b1, lat);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("abort_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("abort_state", {29'd0, bus.state}, 32'd0);
        chk("abort_instret", bus.instret, 32'd0);
        m_instret = '0;
        cur_sel = '0;
        d = '0; d.rst = 1'b1;
        e = base(3'd0, 1'b0); e.imem_req = 1'b1;
        step(d, e);
        run_instr(F_R, 1'b0, 0, 0, 1'b0, lat);       chk("lat_r_after_rst", lat, 4); idle_check(1);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
